// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with a registered, time-multiplexed digit scanner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (bcd_out = 4'hF).
module bcd_counter_scan #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  tick,
   input  logic                  up,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic [3:0]            bcd_out,
   output logic [DIGITS-1:0]     digit_sel
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_RST  = ~DIGITS'(1);

   logic [4*DIGITS-1:0] count_q, count_d;
   logic                wrap_q, wrap_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          bcd_q, bcd_d;
   logic [DIGITS-1:0]   sel_q, sel_d;

   // Ripple carry/borrow through all digits within one cycle.
   always_comb begin
      logic       carry;
      logic [3:0] dig;
      count_d = count_q;
      wrap_d  = 1'b0;
      carry   = 1'b1;
      dig     = 4'd0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         for (int i = 0; i < DIGITS; i++) begin
            dig = load_val[4*i +: 4];
            count_d[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
         end
      end else if (en && tick) begin
         for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
               if (up) begin
                  if (dig == 4'd9) count_d[4*i +: 4] = 4'd0;
                  else begin
                     count_d[4*i +: 4] = dig + 4'd1;
                     carry = 1'b0;
                  end
               end else begin
                  if (dig == 4'd0) count_d[4*i +: 4] = 4'd9;
                  else begin
                     count_d[4*i +: 4] = dig - 4'd1;
                     carry = 1'b0;
                  end
               end
            end
         end
         wrap_d = carry;
      end
   end

   // Select and digit code are computed from the same index so they move together.
   always_comb begin
      logic       zero_above;
      logic [3:0] dig;
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      sel_d      = ~(DIGITS'(1) << idx_d);
      bcd_d      = 4'd0;
      zero_above = 1'b1;
      dig        = 4'd0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         dig        = count_q[4*i +: 4];
         zero_above = zero_above & (dig == 4'd0);
         if (idx_d == IDX_W'(i)) begin
`ifdef LEADING_ZERO_BLANK_EN
            bcd_d = (i > 0 && zero_above) ? 4'hF : dig;
`else
            bcd_d = dig;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         div_q   <= '0;
         idx_q   <= '0;
         bcd_q   <= 4'd0;
         sel_q   <= SEL_RST;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         bcd_q   <= bcd_d;
         sel_q   <= sel_d;
      end
   end

   assign count     = count_q;
   assign wrap      = wrap_q;
   assign bcd_out   = bcd_q;
   assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Directed plus randomized bench for bcd_counter_scan against an integer-valued reference.
module tb_bcd_counter_scan;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 8;
   localparam int MAXV     = 9999;

   logic        clk = 1'b0;
   logic        rst_n, en, tick, up, clear, load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        wrap;
   logic [3:0]  bcd_out;
   logic [3:0]  digit_sel;

   int checks = 0;
   int errors = 0;

   int m_cnt;    // reference count as a plain integer
   int m_edges;  // clock edges since reset release

   bcd_counter_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .up(up), .clear(clear),
      .load(load), .load_val(load_val), .count(count), .wrap(wrap),
      .bcd_out(bcd_out), .digit_sel(digit_sel)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int k);
      int p = 1;
      for (int j = 0; j < k; j++) p = p * 10;
      return p;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction

   function automatic int load_value(input logic [15:0] lv);
      int v = 0;
      for (int k = 0; k < DIGITS; k++) begin
         int f = int'((lv >> (4*k)) & 16'hF);
         if (f > 9) f = 0;
         v = v + f * pow10(k);
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, check all outputs 1 time unit after the edge.
   task automatic cyc(input logic c, input logic l, input logic [15:0] lv,
                      input logic e, input logic t, input logic u);
      int prev, idx, dv, exp_wrap;
      logic [3:0] exp_bcd;
      clear = c; load = l; load_val = lv; en = e; tick = t; up = u;
      @(posedge clk);
      prev     = m_cnt;
      exp_wrap = 0;
      if (c) m_cnt = 0;
      else if (l) m_cnt = load_value(lv);
      else if (e && t) begin
         if (u) begin
            if (m_cnt == MAXV) begin m_cnt = 0; exp_wrap = 1; end
            else m_cnt = m_cnt + 1;
         end else begin
            if (m_cnt == 0) begin m_cnt = MAXV; exp_wrap = 1; end
            else m_cnt = m_cnt - 1;
         end
      end
      m_edges++;
      idx = (m_edges / SCAN_DIV) % DIGITS;
      dv  = prev / pow10(idx);
      exp_bcd = 4'(dv % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0 && dv == 0) exp_bcd = 4'hF;
`endif
      #1;
      chk("count", 32'(count), 32'(to_bcd(m_cnt)));
      chk("wrap", 32'(wrap), 32'(exp_wrap));
      chk("digit_sel", 32'(digit_sel), 32'(~(4'b0001 << idx) & 4'hF));
      chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; tick = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0;
      load_val = '0;
      m_cnt = 0; m_edges = 0;
      #12;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      chk("rst_sel", 32'(digit_sel), 32'hE);
      chk("rst_bcd", 32'(bcd_out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle scan across three slots.
      idle(3 * SCAN_DIV);

      // Up wrap from 9999, then wrap must drop.
      cyc(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
      idle(1);

      // Down wrap from 0, then a plain decrement.
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      idle(1);

      // Illegal fields load as zero; clear beats load.
      cyc(1'b0, 1'b1, 16'h1A3F, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
      // Load has priority over a qualified tick.
      cyc(1'b0, 1'b1, 16'h0250, 1'b1, 1'b1, 1'b1);

      // Leading-zero view of 0042 across every slot.
      cyc(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
      idle(DIGITS * SCAN_DIV + 2);

      // Reset mid-slot while scanning digit 2 of 0123.
      cyc(1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 4 * SCAN_DIV && ((m_edges / SCAN_DIV) % DIGITS) != 2; g++) idle(1);
      idle(SCAN_DIV / 2);
      chk("pre_rst_count", 32'(count), 32'h0123);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_sel", 32'(digit_sel), 32'hE);
      chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
      chk("mid_rst_wrap", 32'(wrap), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      m_cnt = 0; m_edges = 0;
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic, biased toward ticks and occasional loads near the wrap points.
      for (int i = 0; i < 600; i++) begin
         logic [15:0] lv;
         int r = int'($urandom_range(0, 99));
         lv = 16'($urandom);
         if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 1) ? 16'h9998 : 16'h0001;
         cyc(r < 2, r >= 2 && r < 8, lv, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_counter_scan.md
Name: bcd_counter_scan

Overview:
- Multi-digit BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the BCD-to-seven-segment decoder.
- Presents one 4-bit BCD digit per scan slot on bcd_out, which feeds the decoder's 4-bit input, and drives an active-low one-hot digit enable for a common-anode multiplexed display.
- Also exposes the full packed count and a wrap pulse for cascading.

Parameters:
- DIGITS, 4: number of BCD digits. Legal range 2..8.
- SCAN_DIV, 1000: clock cycles each digit stays selected. Must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  count enable; qualifies tick
- tick  in  1  single-cycle count strobe
- up  in  1  direction: 1 = increment, 0 = decrement
- clear  in  1  synchronous clear of the count
- load  in  1  synchronous parallel load
- load_val  in  4*DIGITS  packed BCD load value; digit 0 in [3:0]
- count  out  4*DIGITS  packed BCD count; digit 0 = least significant
- wrap  out  1  one-cycle pulse on 99..9->0 (up) or 0->99..9 (down)
- bcd_out  out  4  BCD code of the currently scanned digit
- digit_sel  out  DIGITS  active-low one-hot digit enable

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0, wrap = 0
  - scan divider = 0, scan index = 0
  - bcd_out = 4'd0, digit_sel = all ones except bit 0 = 0
- Count update, evaluated each clock edge. Priority: clear > load > (en & tick) > hold.
  - clear: count <= 0; wrap = 0.
  - load: each 4-bit field of load_val > 9 is stored as 0; legal fields are stored as given. wrap = 0.
  - en & tick, up = 1: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit (ripple within the same cycle). All digits at 9 -> all 0, and wrap = 1 for exactly the next cycle.
  - en & tick, up = 0: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. All digits at 0 -> all 9, and wrap = 1.
  - tick with en = 0 is ignored.
  - count is a registered output. It reflects an update one cycle after the qualifying edge inputs.
- Scanner, free-running and independent of en/tick/clear/load:
  - Divider counts 0..SCAN_DIV-1.
  - When the divider reaches SCAN_DIV-1, it returns to 0 and the scan index advances. Index runs 0..DIGITS-1, then wraps to 0.
  - digit_sel and bcd_out are registered together, so they change on the same edge. No cycle ever shows a new select with an old digit.
  - bcd_out is sampled from the count register value at that edge, not the pending next count.
  - Exactly one digit_sel bit is low at all times, including reset.
- All outputs are glitch-free registered signals. There is no combinational path from inputs to outputs.
- Reset asserted mid-scan or mid-count returns every output to its reset value immediately. Release takes effect on the first clock edge after rst_n rises.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any scanned digit at position k > 0 whose digit and all higher digits are 0 presents bcd_out = 4'hF. The downstream decoder treats codes 10-15 as all segments off.
  - Digit 0 is never blanked, so count 0 shows a single "0".
  - digit_sel still scans normally.
- Undefined: bcd_out always carries the true digit, including leading zeros.
- The count and wrap outputs are identical in both builds.

Test Plan:
1. Reset, then hold rst_n high 3*SCAN_DIV cycles with DIGITS=4 -> count=0x0000, wrap=0; digit_sel steps 1110, 1101, 1011 at cycles SCAN_DIV and 2*SCAN_DIV; bcd_out=0 throughout.
2. load=1 with load_val=0x9999, then en=1, tick=1, up=1 for one cycle -> count=0x0000; wrap high for exactly one cycle.
3. count=0x0000, en=1, tick=1, up=0 -> count=0x9999 and wrap pulse. A second tick -> 0x9998 with no wrap.
4. load_val=0x1A3F with load=1 -> count=0x1030. Same cycle with clear=1 and load=1 -> count=0x0000.
5. count=0x0042 under LEADING_ZERO_BLANK_EN -> bcd_out per slot: digit0=2, digit1=4, digit2=F, digit3=F. Without the macro -> 2, 4, 0, 0.
6. Assert rst_n low mid-slot while count=0x0123 and index=2 -> same cycle, count=0, digit_sel=1110, bcd_out=0. tick with en=0 after release leaves count unchanged.
